// File: rtl/abc_result_accum.sv
// Frame accumulator behind the 17-bit add/subtract datapath: sums PI_len results
// with saturation, tracks the frame maximum and holds the total until it is taken.
module abc_result_accum #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 25,
  parameter int LEN_W = 8
) (
  input  logic             PI_clk,
  input  logic             PI_rst_n,
  input  logic             PI_clear,
  input  logic [LEN_W-1:0] PI_len,
  input  logic             PI_in_valid,
  output logic             PO_in_ready,
  input  logic [IN_W-1:0]  PI_in_data,
  output logic             PO_sum_valid,
  input  logic             PI_sum_ready,
  output logic [ACC_W-1:0] PO_sum,
  output logic [IN_W-1:0]  PO_max,
  output logic             PO_ovf,
  output logic [LEN_W-1:0] PO_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [IN_W-1:0]  max_q, max_d, omax_q, omax_d;
  logic             ovf_q, ovf_d, oovf_q, oovf_d;
  logic [LEN_W-1:0] count_q, count_d, len_q, len_d;

  logic             beat;
  logic             last;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] len_m1;
  logic [ACC_W:0]   acc_wide;
  logic [ACC_W-1:0] acc_new;
  logic [IN_W-1:0]  max_new;
  logic             ovf_new;

  always_comb begin
    beat     = PI_in_valid && (state_q == ACCUM);
    // The frame length is taken live on the first beat, latched afterwards.
    eff_len  = (count_q == '0) ? PI_len : len_q;
    // Modular subtraction makes len 0 terminate at count 2^LEN_W-1.
    len_m1   = eff_len - LEN_W'(1);
    last     = (count_q == len_m1);
    acc_wide = {1'b0, acc_q} + (ACC_W+1)'(PI_in_data);
    acc_new  = acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];
    ovf_new  = ovf_q | acc_wide[ACC_W];
    max_new  = (PI_in_data > max_q) ? PI_in_data : max_q;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    len_d   = len_q;
    sum_d   = sum_q;
    omax_d  = omax_q;
    oovf_d  = oovf_q;

    unique case (state_q)
      ACCUM: begin
        if (beat) begin
          if (count_q == '0) len_d = PI_len;
          if (last) begin
            sum_d   = acc_new;
            omax_d  = max_new;
            oovf_d  = ovf_new;
            acc_d   = '0;
            max_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
            state_d = HOLD;
          end else begin
            acc_d   = acc_new;
            max_d   = max_new;
            ovf_d   = ovf_new;
            count_d = count_q + LEN_W'(1);
          end
        end
      end
      HOLD: begin
        if (PI_sum_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase

    if (PI_clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      max_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
      sum_d   = '0;
      omax_d  = '0;
      oovf_d  = 1'b0;
    end
  end

  always_ff @(posedge PI_clk or negedge PI_rst_n) begin
    if (!PI_rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      omax_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      omax_q  <= omax_d;
      oovf_q  <= oovf_d;
    end
  end

  assign PO_in_ready  = (state_q == ACCUM);
  assign PO_sum_valid = (state_q == HOLD);
  assign PO_sum       = sum_q;
  assign PO_max       = omax_q;
  assign PO_ovf       = oovf_q;
  assign PO_count     = count_q;

endmodule

// File: tb/tb_abc_result_accum.sv
// Bench for abc_result_accum: two instances (ACC_W 25 and 18) share stimulus and
// are checked every cycle against a queue-based frame model.
module tb_abc_result_accum;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [7:0]  len;
  logic        in_valid;
  logic [16:0] in_data;
  logic        sum_ready;

  logic        rdy_a, sv_a, ovf_a, rdy_b, sv_b, ovf_b;
  logic [24:0] sum_a;
  logic [17:0] sum_b;
  logic [16:0] max_a, max_b;
  logic [7:0]  cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  abc_result_accum #(.IN_W(17), .ACC_W(25), .LEN_W(8)) dut_a (
    .PI_clk(clk), .PI_rst_n(rst_n), .PI_clear(clear), .PI_len(len),
    .PI_in_valid(in_valid), .PO_in_ready(rdy_a), .PI_in_data(in_data),
    .PO_sum_valid(sv_a), .PI_sum_ready(sum_ready), .PO_sum(sum_a),
    .PO_max(max_a), .PO_ovf(ovf_a), .PO_count(cnt_a)
  );

  abc_result_accum #(.IN_W(17), .ACC_W(18), .LEN_W(8)) dut_b (
    .PI_clk(clk), .PI_rst_n(rst_n), .PI_clear(clear), .PI_len(len),
    .PI_in_valid(in_valid), .PO_in_ready(rdy_b), .PI_in_data(in_data),
    .PO_sum_valid(sv_b), .PI_sum_ready(sum_ready), .PO_sum(sum_b),
    .PO_max(max_b), .PO_ovf(ovf_b), .PO_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Frame model: the samples of the open frame live in a queue; totals are
  // computed from the whole frame when it closes.
  int      q[$];
  int      m_len;
  bit      m_hold;
  longint  m_sum_a, m_sum_b;
  int      m_max;
  bit      m_ovf_a, m_ovf_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_len = 0; m_hold = 0;
      m_sum_a = 0; m_sum_b = 0; m_max = 0; m_ovf_a = 0; m_ovf_b = 0;
    end else if (clear) begin
      q.delete();
      m_hold = 0;
      m_sum_a = 0; m_sum_b = 0; m_max = 0; m_ovf_a = 0; m_ovf_b = 0;
    end else if (m_hold) begin
      if (sum_ready) m_hold = 0;
    end else if (in_valid) begin
      longint tot;
      if (q.size() == 0) m_len = (len == 0) ? 256 : int'(len);
      q.push_back(int'(in_data));
      if (q.size() == m_len) begin
        tot = 0; m_max = 0;
        foreach (q[i]) begin
          tot += q[i];
          if (q[i] > m_max) m_max = q[i];
        end
        m_ovf_a = (tot > 64'h1FF_FFFF);
        m_ovf_b = (tot > 64'h3_FFFF);
        m_sum_a = m_ovf_a ? 64'h1FF_FFFF : tot;
        m_sum_b = m_ovf_b ? 64'h3_FFFF : tot;
        q.delete();
        m_hold = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_a", rdy_a, !m_hold);
      chk("valid_a", sv_a, m_hold);
      chk("count_a", cnt_a, q.size());
      chk("sum_a", sum_a, m_sum_a);
      chk("max_a", max_a, m_max);
      chk("ovf_a", ovf_a, m_ovf_a);
      chk("ready_b", rdy_b, !m_hold);
      chk("valid_b", sv_b, m_hold);
      chk("count_b", cnt_b, q.size());
      chk("sum_b", sum_b, m_sum_b);
      chk("max_b", max_b, m_max);
      chk("ovf_b", ovf_b, m_ovf_b);
    end
  end

  // Presents one beat from a falling edge and returns at the falling edge after acceptance.
  task automatic beat(input logic [16:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!rdy_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("beat_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_sum();
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; len = 8'd4; in_valid = 1'b0; in_data = '0; sum_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", rdy_a, 1);
    chk("rst_valid", sv_a, 0);
    chk("rst_sum", sum_a, 0);
    chk("rst_count", cnt_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame of four.
    beat(17'd1); beat(17'd2); beat(17'd3); beat(17'd4);
    chk("t1_valid", sv_a, 1);
    chk("t1_sum", sum_a, 10);
    chk("t1_max", max_a, 4);
    chk("t1_ovf", ovf_a, 0);
    repeat (2) @(negedge clk);
    chk("t1_ready_held", rdy_a, 0);
    release_sum();
    chk("t1_ready_back", rdy_a, 1);

    // Saturation on the 18-bit instance.
    len = 8'd3;
    repeat (3) beat(17'h1FFFF);
    chk("t2_sum_b", sum_b, 18'h3FFFF);
    chk("t2_ovf_b", ovf_b, 1);
    chk("t2_max_b", max_b, 17'h1FFFF);
    chk("t2_sum_a", sum_a, 25'h5FFFD);
    release_sum();
    repeat (3) beat(17'd1);
    chk("t2b_sum_b", sum_b, 3);
    chk("t2b_ovf_b", ovf_b, 0);
    release_sum();

    // Length 0 frame with random gaps and a mid-frame length change.
    len = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) len = 8'd3;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      beat(17'd1);
    end
    chk("t3_valid", sv_a, 1);
    chk("t3_sum", sum_a, 256);
    chk("t3_count", cnt_a, 0);
    release_sum();

    // Long hold with valid asserted.
    len = 8'd2;
    beat(17'd3); beat(17'd5);
    in_valid = 1'b1; in_data = 17'd9;
    repeat (5) @(negedge clk);
    chk("t4_sum_stable", sum_a, 8);
    chk("t4_count_idle", cnt_a, 0);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk("t4_ready", rdy_a, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_first_beat", cnt_a, 1);
    beat(17'd2);
    chk("t4_sum", sum_a, 11);
    chk("t4_max", max_a, 9);
    release_sum();

    // Clear mid-frame (with a beat offered in the same cycle), then in HOLD.
    len = 8'd4;
    beat(17'd7); beat(17'd9);
    clear = 1'b1; in_valid = 1'b1; in_data = 17'd100;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_count", cnt_a, 0);
    chk("t5_sum_cleared", sum_a, 0);
    repeat (4) beat(17'd1);
    chk("t5_sum", sum_a, 4);
    chk("t5_max", max_a, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_hold_clear", sv_a, 0);

    // Asynchronous reset mid-frame with non-zero held outputs.
    len = 8'd2;
    beat(17'd6); beat(17'd6);
    release_sum();
    beat(17'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready", rdy_a, 1);
    chk("t6_valid", sv_a, 0);
    chk("t6_sum", sum_a, 0);
    chk("t6_max", max_a, 0);
    chk("t6_ovf", ovf_a, 0);
    chk("t6_count", cnt_a, 0);
    chk("t6_sum_b", sum_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", rdy_a, 1);
    len = 8'd1;
    beat(17'd42);
    chk("t6_len1_sum", sum_a, 42);
    chk("t6_len1_valid", sv_a, 1);
    release_sum();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
